// File: rtl/des_perm_pipe.sv
// Pipelined DES bit-permutation engine (P, P inverse, IP, FP) with a per-beat mode
// carried through STAGES register slices under valid/ready flow control.
module des_perm_pipe #(
    parameter int unsigned STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mode,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_mode,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int unsigned DW = 64;
    localparam int unsigned HW = 32;
    localparam int unsigned MW = 2;

    localparam logic [MW-1:0] MODE_P    = 2'd0;
    localparam logic [MW-1:0] MODE_PINV = 2'd1;
    localparam logic [MW-1:0] MODE_IP   = 2'd2;
    localparam logic [MW-1:0] MODE_FP   = 2'd3;

    // Tables list, for each output bit (DES numbering, 1 = MSB), the source input bit.
    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int unsigned FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    function automatic logic [HW-1:0] p_fwd(input logic [HW-1:0] x);
        logic [HW-1:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TAB[5'(i)])];
        return y;
    endfunction

    // Inverse P scatters each input bit back to the position P gathered it from.
    function automatic logic [HW-1:0] p_inv(input logic [HW-1:0] x);
        logic [HW-1:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(32 - P_TAB[5'(i)])] = x[5'(31 - i)];
        return y;
    endfunction

    function automatic logic [DW-1:0] perm64(input logic [DW-1:0] x, input logic sel_fp);
        logic [DW-1:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            if (sel_fp) y[6'(63 - i)] = x[6'(64 - FP_TAB[6'(i)])];
            else        y[6'(63 - i)] = x[6'(64 - IP_TAB[6'(i)])];
        end
        return y;
    endfunction

    logic [DW-1:0] perm_c;

    always_comb begin
        perm_c = '0;
        case (in_mode)
            MODE_P:    perm_c = {32'h0, p_fwd(in_data[HW-1:0])};
            MODE_PINV: perm_c = {32'h0, p_inv(in_data[HW-1:0])};
            MODE_IP:   perm_c = perm64(in_data, 1'b0);
            MODE_FP:   perm_c = perm64(in_data, 1'b1);
            default:   perm_c = '0;
        endcase
    end

    logic          v [STAGES];
    logic [DW-1:0] d [STAGES];
    logic [MW-1:0] m [STAGES];
    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] r;

    // A stage may load when out_ready is high or any stage from it to the output is empty.
    for (genvar k = 0; k < STAGES; k++) begin : g_ready
        assign v_vec[k] = v[k];
        assign r[k]     = out_ready | ~(&v_vec[STAGES-1:k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v[0] <= 1'b0;
            d[0] <= '0;
            m[0] <= '0;
        end else if (r[0]) begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= perm_c;
                m[0] <= in_mode;
            end
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k] <= 1'b0;
                d[k] <= '0;
                m[k] <= '0;
            end else if (r[k]) begin
                v[k] <= v[k-1];
                if (v[k-1]) begin
                    d[k] <= d[k-1];
                    m[k] <= m[k-1];
                end
            end
        end
    end

    assign in_ready  = r[0];
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign out_mode  = m[STAGES-1];
    assign busy      = |v_vec;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: four instances (STAGES 1..4) checked against a table-driven
// reference model and an in-flight scoreboard per instance.
module tb_des_perm_pipe;

    localparam int unsigned NI = 4;

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int unsigned FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    typedef struct {
        logic [63:0] data;
        logic [1:0]  mode;
        int          cyc;
        logic        lat;
        logic        has_gold;
        logic [63:0] gold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid [NI];
    logic        in_ready [NI];
    logic [1:0]  in_mode  [NI];
    logic [63:0] in_data  [NI];
    logic        out_valid[NI];
    logic        out_ready[NI];
    logic [1:0]  out_mode [NI];
    logic [63:0] out_data [NI];
    logic        busy     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        des_perm_pipe #(.STAGES(g + 1)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_mode  (in_mode[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_mode (out_mode[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    exp_t        q [NI][$];
    int          errors;
    int          checks;
    int          cyc;
    logic        acc       [NI];
    logic        stall_prev[NI];
    logic [63:0] prev_d    [NI];
    logic [1:0]  prev_m    [NI];
    logic        rand_or   [NI];
    logic        lat_en;
    logic        gold_en;
    logic [63:0] gold_val;

    // DES bit n of a w-bit operand, bit 1 being the MSB.
    function automatic logic des_bit(input logic [63:0] x, input int unsigned n,
                                     input int unsigned w);
        logic [63:0] t;
        t = x >> (w - n);
        return t[0];
    endfunction

    function automatic logic [63:0] ref_perm(input logic [1:0] mode, input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        case (mode)
            2'd0: for (int i = 0; i < 32; i++) y = {y[62:0], des_bit(x, P_T[5'(i)], 32)};
            2'd1: for (int j = 1; j <= 32; j++)
                      for (int i = 0; i < 32; i++)
                          if (P_T[5'(i)] == 32'(j)) y = {y[62:0], des_bit(x, 32'(i + 1), 32)};
            2'd2: for (int i = 0; i < 64; i++) y = {y[62:0], des_bit(x, IP_T[6'(i)], 64)};
            default: for (int i = 0; i < 64; i++) y = {y[62:0], des_bit(x, FP_T[6'(i)], 64)};
        endcase
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge: the values seen here are what the next rising edge commits.
    task automatic monitor(input int g);
        exp_t e;
        int   n;
        n = q[g].size();
        chk("in_ready", 64'(in_ready[g]), 64'(out_ready[g] || (n < g + 1)));
        chk("busy", 64'(busy[g]), 64'(n > 0));
        if (n == 0) chk("out_valid_idle", 64'(out_valid[g]), 64'(0));
        if (stall_prev[g]) begin
            chk("stall_valid", 64'(out_valid[g]), 64'(1));
            chk("stall_data", out_data[g], prev_d[g]);
            chk("stall_mode", 64'(out_mode[g]), 64'(prev_m[g]));
        end
        if (out_valid[g] && out_ready[g] && n > 0) begin
            e = q[g].pop_front();
            chk("out_data", out_data[g], e.data);
            chk("out_mode", 64'(out_mode[g]), 64'(e.mode));
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(g + 1));
            if (e.has_gold) chk("golden", out_data[g], e.gold);
        end
        acc[g] = in_valid[g] && in_ready[g];
        if (acc[g]) begin
            e.data     = ref_perm(in_mode[g], in_data[g]);
            e.mode     = in_mode[g];
            e.cyc      = cyc;
            e.lat      = lat_en;
            e.has_gold = gold_en;
            e.gold     = gold_val;
            q[g].push_back(e);
        end
        stall_prev[g] = out_valid[g] && !out_ready[g];
        prev_d[g]     = out_data[g];
        prev_m[g]     = out_mode[g];
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int g = 0; g < NI; g++) monitor(g);
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++)
            if (rand_or[g]) out_ready[g] = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int g, input logic [1:0] mode, input logic [63:0] data,
                        output int nt);
        in_valid[g] = 1'b1;
        in_mode[g]  = mode;
        in_data[g]  = data;
        nt = 0;
        do begin
            tick();
            nt++;
        end while (!acc[g] && nt < 200);
        if (!acc[g]) chk("send_timeout", 64'(acc[g]), 64'(1));
        in_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        int nt;
        rand_or[g]   = 1'b0;
        out_ready[g] = 1'b1;
        nt = 0;
        while (q[g].size() != 0 && nt < 100) begin
            tick();
            nt++;
        end
        chk("drain", 64'(q[g].size()), 64'(0));
        tick();
        tick();
    endtask

    task automatic reset_checks();
        for (int g = 0; g < NI; g++) begin
            chk("rst_out_valid", 64'(out_valid[g]), 64'(0));
            chk("rst_out_data", out_data[g], 64'(0));
            chk("rst_out_mode", 64'(out_mode[g]), 64'(0));
            chk("rst_busy", 64'(busy[g]), 64'(0));
            chk("rst_in_ready", 64'(in_ready[g]), 64'(1));
        end
    endtask

    // Pulse between edges; in-flight beats are discarded by the design and by the scoreboard.
    task automatic reset_pulse();
        for (int g = 0; g < NI; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            rand_or[g]   = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        reset_checks();
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) begin
            q[g].delete();
            stall_prev[g] = 1'b0;
        end
    endtask

    initial begin
        int          nt;
        logic [63:0] p;
        errors = 0; checks = 0; cyc = 0;
        lat_en = 1'b0; gold_en = 1'b0; gold_val = '0;
        for (int g = 0; g < NI; g++) begin
            in_valid[g] = 1'b0; in_mode[g] = '0; in_data[g] = '0;
            out_ready[g] = 1'b0; acc[g] = 1'b0; stall_prev[g] = 1'b0;
            prev_d[g] = '0; prev_m[g] = '0; rand_or[g] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vectors on STAGES=2, back-to-back, with latency checking
        out_ready[1] = 1'b1;
        lat_en  = 1'b1;
        gold_en = 1'b1;
        gold_val = 64'h0000_0000_480F_F596; send(1, 2'd0, 64'h0000_0000_5FE4_612A, nt);
        gold_val = 64'h0000_0000_1935_8DE4; send(1, 2'd0, 64'h0000_0000_40E8_EA6D, nt);
        gold_val = 64'h0000_0000_480F_F596; send(1, 2'd0, 64'hDEAD_BEEF_5FE4_612A, nt);
        p = ref_perm(2'd0, 64'h8956_5092);
        gold_en = 1'b0;                     send(1, 2'd0, 64'h0000_0000_8956_5092, nt);
        gold_en = 1'b1;
        gold_val = 64'h0000_0000_8956_5092; send(1, 2'd1, p, nt);
        gold_val = 64'h0000_0000_480F_F596; send(1, 2'd0, 64'h0000_0000_5FE4_612A, nt);
        gold_val = 64'hCC00_CCFF_F0AA_F0AA; send(1, 2'd2, 64'h0123_4567_89AB_CDEF, nt);
        gold_val = 64'h0000_0000_8956_5092; send(1, 2'd1, {32'hFFFF_0000, p[31:0]}, nt);
        gold_val = 64'h0123_4567_89AB_CDEF; send(1, 2'd3, 64'hCC00_CCFF_F0AA_F0AA, nt);
        gold_en = 1'b0;
        drain(1);
        lat_en = 1'b0;

        // Random backpressure, 32-bit modes, STAGES=2
        rand_or[1] = 1'b1;
        for (int i = 0; i < 10; i++)
            send(1, 2'($urandom_range(0, 1)), {$urandom, $urandom}, nt);
        drain(1);

        // Random modes and backpressure on every depth
        for (int g = 0; g < NI; g++) begin
            rand_or[g] = 1'b1;
            for (int i = 0; i < 30; i++)
                send(g, 2'($urandom_range(0, 3)), {$urandom, $urandom}, nt);
            drain(g);
        end

        // Full STAGES=3 pipe: blocked, then simultaneous pop and push
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) send(2, 2'($urandom_range(0, 3)), {$urandom, $urandom}, nt);
        in_valid[2] = 1'b1; in_mode[2] = 2'd2; in_data[2] = {$urandom, $urandom};
        #1 chk("full_in_ready", 64'(in_ready[2]), 64'(0));
        out_ready[2] = 1'b1;
        #1 chk("poppush_in_ready", 64'(in_ready[2]), 64'(1));
        tick();
        chk("poppush_accept", 64'(acc[2]), 64'(1));
        in_valid[2] = 1'b0; out_ready[2] = 1'b0;
        #1 chk("refull_in_ready", 64'(in_ready[2]), 64'(0));
        drain(2);

        // Asynchronous reset with beats in flight
        out_ready[2] = 1'b0; out_ready[3] = 1'b0;
        for (int i = 0; i < 3; i++) send(2, 2'($urandom_range(0, 3)), {$urandom, $urandom}, nt);
        for (int i = 0; i < 3; i++) send(3, 2'($urandom_range(0, 3)), {$urandom, $urandom}, nt);
        reset_pulse();
        out_ready[2] = 1'b1; out_ready[3] = 1'b1;
        in_valid[2] = 1'b1; in_mode[2] = 2'd0; in_data[2] = {$urandom, $urandom};
        tick();
        chk("post_reset_accept", 64'(acc[2]), 64'(1));
        in_valid[2] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        drain(2);
        drain(3);

        // Depth sweep: latency equals STAGES and one beat per cycle
        lat_en = 1'b1;
        for (int g = 0; g < NI; g++) begin
            out_ready[g] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                send(g, 2'($urandom_range(0, 3)), {$urandom, $urandom}, nt);
                chk("throughput", 64'(nt), 64'(1));
            end
            drain(g);
        end
        lat_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
